// File: rtl/piso_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : piso_pkg
//  Description : Shared types and constants for the PISO frame controller:
//                FSM state encoding, default frame geometry and the helper
//                that sizes the bit counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package piso_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int c_DEF_WIDTH = 4;
    localparam int c_DEF_GAP   = 0;
    localparam int c_GAP_CNT_W = 4;   // holds 0..15 idle cycles

    // Bit counter width; never narrower than one bit.
    function automatic int cnt_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/d_ff.sv
`default_nettype none
// ============================================================================
//  Module      : d_ff
//  Description : Single-bit storage cell with synchronous active-low clear,
//                synchronous set and load enable. Clear beats set beats load.
//  Ports       : clk   - clock, rising edge
//                rst   - synchronous clear, active-low
//                i_set - force q to 1
//                i_en  - load i_d
//                i_d   - data in
//                o_q   - stored bit
//  Revision    : 1.0 - initial release
// ============================================================================
module d_ff (
    input  logic clk,
    input  logic rst,
    input  logic i_set,
    input  logic i_en,
    input  logic i_d,
    output logic o_q
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q <= 1'b0;
        end else if (i_set) begin
            r_q <= 1'b1;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/piso_shift_core.sv
`default_nettype none
// ============================================================================
//  Module      : piso_shift_core
//  Description : WIDTH-bit parallel-load shift register built from d_ff cells.
//                The head bit is presented on o_ser_out; each shift moves the
//                next bit into the head position and fills with zero.
//  Ports       : clk        - clock, rising edge
//                rst        - synchronous clear, active-low
//                i_load     - load i_d (wins over i_shift_en)
//                i_shift_en - advance by one bit
//                i_d        - parallel word
//                o_ser_out  - current head bit
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_shift_core
    import piso_pkg::*;
#(
    parameter int WIDTH     = c_DEF_WIDTH,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift_en,
    input  logic [WIDTH-1:0] i_d,
    output logic             o_ser_out
);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_nxt;
    logic             w_en;

    // MSB-first drains from the top, so bits move upward; LSB-first drains
    // from bit 0, so bits move downward.
    assign w_shift = (MSB_FIRST != 0) ? {w_q[WIDTH-2:0], 1'b0}
                                      : {1'b0, w_q[WIDTH-1:1]};
    assign w_nxt   = i_load ? i_d : w_shift;
    assign w_en    = i_load | i_shift_en;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            d_ff u_ff (
                .clk   (clk),
                .rst   (rst),
                .i_set (1'b0),
                .i_en  (w_en),
                .i_d   (w_nxt[gi]),
                .o_q   (w_q[gi])
            );
        end
    endgenerate

    assign o_ser_out = (MSB_FIRST != 0) ? w_q[WIDTH-1] : w_q[0];

endmodule
`default_nettype wire

// File: rtl/piso_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : piso_frame_ctrl
//  Description : Sequencer for the parallel-in/serial-out path. Accepts one
//                word per valid/ready handshake, shifts it out one bit per
//                clock with frame_start/done markers, then optionally idles
//                GAP cycles before the next frame.
//  Ports       : clk           - clock, rising edge
//                rst           - synchronous reset, active-low
//                i_in_valid    - producer offers i_in_data
//                i_in_data     - parallel word (WIDTH bits)
//                o_in_ready    - word can be accepted this cycle
//                o_ser_out     - serial bit, meaningful while o_ser_valid
//                o_ser_valid   - o_ser_out carries a frame bit
//                o_frame_start - pulse with the first bit of a frame
//                o_done        - pulse with the last bit of a frame
//                o_busy        - in SHIFT or GAP
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_frame_ctrl
    import piso_pkg::*;
#(
    parameter int WIDTH     = c_DEF_WIDTH,
    parameter int MSB_FIRST = 0,
    parameter int GAP       = c_DEF_GAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_in_valid,
    input  logic [WIDTH-1:0] i_in_data,
    output logic             o_in_ready,
    output logic             o_ser_out,
    output logic             o_ser_valid,
    output logic             o_frame_start,
    output logic             o_done,
    output logic             o_busy
);

    localparam int                     c_CNT_W    = cnt_w(WIDTH);
    localparam logic [c_CNT_W-1:0]     c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_GAP_CNT_W-1:0] c_GAP_LAST = c_GAP_CNT_W'((GAP > 0) ? GAP - 1 : 0);

    state_t                 r_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_GAP_CNT_W-1:0] r_gcnt;

    state_t                 w_state_nxt;
    logic [c_CNT_W-1:0]     w_cnt_nxt;
    logic [c_GAP_CNT_W-1:0] w_gcnt_nxt;
    logic                   w_load;
    logic                   w_shift_en;
    logic                   w_in_ready;
    logic                   w_accept;
    logic                   w_cnt_last;
    logic                   w_gap_last;
    logic                   w_shifting;

    assign w_cnt_last = (r_cnt == c_CNT_LAST);
    assign w_gap_last = (r_gcnt == c_GAP_LAST);
    assign w_shifting = (r_state == ST_SHIFT);

    // Ready is a pure decode of registered state; rst gating makes a word
    // offered during reset impossible to accept.
    assign w_in_ready = rst & ((r_state == ST_IDLE) |
                               (w_shifting & w_cnt_last & (GAP == 0)));
    assign w_accept   = i_in_valid & w_in_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_gcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gcnt  <= w_gcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_gcnt_nxt  = r_gcnt;
        w_load      = 1'b0;
        w_shift_en  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_load      = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_shift_en = 1'b1;
                if (w_cnt_last) begin
                    w_cnt_nxt = '0;
                    if (GAP > 0) begin
                        w_gcnt_nxt  = '0;
                        w_state_nxt = ST_GAP;
                    end else if (w_accept) begin
                        // Back-to-back: reload replaces the final shift.
                        w_load      = 1'b1;
                        w_state_nxt = ST_SHIFT;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (w_gap_last) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gcnt_nxt = r_gcnt + c_GAP_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    piso_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_shift_en (w_shift_en),
        .i_d        (i_in_data),
        .o_ser_out  (o_ser_out)
    );

    assign o_in_ready    = w_in_ready;
    assign o_ser_valid   = rst & w_shifting;
    assign o_frame_start = rst & w_shifting & (r_cnt == '0);
    assign o_done        = rst & w_shifting & w_cnt_last;
    assign o_busy        = rst & (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_piso_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piso_frame_ctrl
//  Description : Scoreboard bench for piso_frame_ctrl. Four instances cover
//                LSB/MSB-first, GAP 0/1/2 and an odd width. A timeline model
//                predicts acceptance edges, ready/busy windows and the exact
//                cycle of every serial bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_frame_ctrl;

    localparam int N_DUT = 4;

    typedef struct {
        int   cyc;
        logic b;
        logic s;
        logic d;
    } ent_t;

    logic             clk  = 1'b0;
    logic             rst  = 1'b0;
    logic             stop = 1'b0;
    logic [N_DUT-1:0] vld  = '0;
    logic [7:0]       dat [N_DUT];
    logic [N_DUT-1:0] rdy, so, sv, fs, dn, bz;

    int   cyc         = 0;
    int   vectors     = 0;
    int   miscompares = 0;
    bit   armed       = 1'b0;
    int   next_ok  [N_DUT];
    int   busy_end [N_DUT];
    int   acc_edge [N_DUT];
    int   didx     [N_DUT];
    ent_t sb       [N_DUT][$];
    logic [7:0] dir_words [5] = '{8'hB, 8'hA, 8'h5, 8'hF, 8'h3};

    function automatic int w_of(input int i);
        return (i == 3) ? 5 : 4;
    endfunction
    function automatic bit msb_of(input int i);
        return (i == 1) || (i == 3);
    endfunction
    function automatic int gap_of(input int i);
        return (i == 2) ? 2 : ((i == 3) ? 1 : 0);
    endfunction

    generate
        for (genvar g = 0; g < N_DUT; g++) begin : g_dut
            localparam int W  = (g == 3) ? 5 : 4;
            localparam int MF = (g == 1 || g == 3) ? 1 : 0;
            localparam int GP = (g == 2) ? 2 : ((g == 3) ? 1 : 0);
            piso_frame_ctrl #(
                .WIDTH     (W),
                .MSB_FIRST (MF),
                .GAP       (GP)
            ) u_dut (
                .clk           (clk),
                .rst           (rst),
                .i_in_valid    (vld[g]),
                .i_in_data     (dat[g][W-1:0]),
                .o_in_ready    (rdy[g]),
                .o_ser_out     (so[g]),
                .o_ser_valid   (sv[g]),
                .o_frame_start (fs[g]),
                .o_done        (dn[g]),
                .o_busy        (bz[g])
            );
        end
    endgenerate

    always #5 clk = ~clk;

    task automatic check(input string nm, input int i, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d cycle %0d: got %b expected %b", nm, i, cyc, act, exp);
        end
    endtask

    // Reference timeline: an accept at edge N owns bit cycles N..N+W-1,
    // is busy until N+W+GAP, and the next accept may land at edge N+W when
    // GAP==0, otherwise at N+W+GAP+1 (one IDLE cycle after the gap).
    always @(posedge clk) begin
        ent_t e;
        cyc = cyc + 1;
        if (!rst) armed = 1'b1;
        for (int i = 0; i < N_DUT; i++) begin
            if (!rst) begin
                sb[i].delete();
                next_ok[i]  = cyc + 1;
                busy_end[i] = cyc;
            end else if (armed && vld[i] && cyc >= next_ok[i]) begin
                for (int k = 0; k < w_of(i); k++) begin
                    e.cyc = cyc + k;
                    e.b   = dat[i][msb_of(i) ? (w_of(i) - 1 - k) : k];
                    e.s   = (k == 0);
                    e.d   = (k == w_of(i) - 1);
                    sb[i].push_back(e);
                end
                busy_end[i] = cyc + w_of(i) + gap_of(i);
                next_ok[i]  = cyc + w_of(i) + ((gap_of(i) > 0) ? gap_of(i) + 1 : 0);
                acc_edge[i] = cyc;
            end
        end
    end

    // Monitor: compares every output mid-cycle and pops the scoreboard
    // whenever a bit is due.
    always @(negedge clk) begin
        ent_t e;
        logic ev, eb, es, ed;
        if (armed) begin
            for (int i = 0; i < N_DUT; i++) begin
                check("in_ready", i, rdy[i], rst && (cyc + 1 >= next_ok[i]));
                check("busy", i, bz[i], rst && (cyc < busy_end[i]));
                ev = 1'b0; eb = 1'b0; es = 1'b0; ed = 1'b0;
                if (sb[i].size() > 0 && sb[i][0].cyc == cyc) begin
                    e  = sb[i].pop_front();
                    ev = rst;
                    eb = e.b;
                    es = e.s && rst;
                    ed = e.d && rst;
                end
                check("ser_valid", i, sv[i], ev);
                if (ev) check("ser_out", i, so[i], eb);
                check("frame_start", i, fs[i], es);
                check("done", i, dn[i], ed);
            end
        end
    end

    // Driver: holds each offered word until the model accepts it.
    initial begin
        for (int i = 0; i < N_DUT; i++) begin
            dat[i]      = '0;
            didx[i]     = 0;
            acc_edge[i] = -1;
        end
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < N_DUT; i++) begin
                if (stop) begin
                    vld[i] = 1'b0;
                end else if (!vld[i] || acc_edge[i] == cyc) begin
                    if (didx[i] < 5) begin
                        dat[i]  = dir_words[didx[i]];
                        vld[i]  = 1'b1;
                        didx[i] = didx[i] + 1;
                    end else begin
                        vld[i] = ($urandom_range(0, 3) != 0);
                        dat[i] = 8'($urandom);
                    end
                end
            end
        end
    end

    initial begin
        int nfs;
        int k;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Abort the fourth frame of instance 0 after its second bit.
        nfs = 0;
        k   = 0;
        while (nfs < 4 && k < 300) begin
            @(negedge clk);
            if (fs[0]) nfs++;
            k++;
        end
        if (nfs < 4) begin
            vectors++;
            miscompares++;
            $display("FAIL frame_wait dut0: got %0d frame starts expected 4", nfs);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;

        repeat (600) begin
            @(posedge clk);
            #1 rst = ($urandom_range(0, 63) != 0);
        end
        @(posedge clk);
        #1 rst  = 1'b1;
        stop = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < N_DUT; i++) begin
            vectors++;
            if (sb[i].size() != 0) begin
                miscompares++;
                $display("FAIL drain dut%0d: got %0d pending bits expected 0", i, sb[i].size());
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
